// File: rtl/qconv_job_launcher.sv
// -----------------------------------------------------------------------------
// qconv_job_launcher
//
// Host-side initiator for the qconv_states start/finish handshake. It accepts a
// job naming how many output-channel-tile passes to run. For each pass it
// issues a one-cycle start pulse and waits for the matching finish pulse, with
// a per-pass watchdog. At the end it reports completion, the number of passes
// finished, and sticky error flags. This block is the only driver of
// qconv_states.start.
//
// Ports:
//   clk           in   clock, all logic on rising edge
//   rst           in   synchronous active-high reset
//   job_valid     in   job request valid
//   job_ready     out  launcher can accept a job (IDLE and not in reset)
//   job_count     in   number of start/finish passes for the job
//   qconv_start   out  one-cycle start pulse to qconv_states
//   qconv_finish  in   one-cycle finish pulse from qconv_states
//   busy          out  high whenever the state is not IDLE
//   done          out  one-cycle pulse when a job ends (normal, zero, timeout)
//   passes_done   out  finish pulses counted for the current/last job
//   timeout_err   out  sticky: a pass timed out
//   protocol_err  out  sticky: a finish pulse arrived outside WAIT
// -----------------------------------------------------------------------------
module qconv_job_launcher #(
   parameter int JobCountWidth = 8,
   parameter int TimeoutWidth  = 16,
   parameter int TimeoutCycles = 1000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     job_valid,
   output logic                     job_ready,
   input  logic [JobCountWidth-1:0] job_count,
   output logic                     qconv_start,
   input  logic                     qconv_finish,
   output logic                     busy,
   output logic                     done,
   output logic [JobCountWidth-1:0] passes_done,
   output logic                     timeout_err,
   output logic                     protocol_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // The timer counts WAIT cycles from 0; reaching TimeoutCycles-1 without a
   // finish means this was the last allowed WAIT cycle.
   localparam logic [TimeoutWidth-1:0]  TimerLast = TimeoutWidth'(TimeoutCycles - 1);
   localparam logic [TimeoutWidth-1:0]  TimerMax  = TimeoutWidth'(TimeoutCycles);
   localparam logic [JobCountWidth-1:0] CountOne  = JobCountWidth'(1);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [JobCountWidth-1:0]  r_remaining;
   logic [JobCountWidth-1:0]  r_passes_done;
   logic [TimeoutWidth-1:0]   r_timer;
   logic                      r_timeout_err;
   logic                      r_protocol_err;
   logic                      w_accept;
   logic                      w_wait_finish;
   logic                      w_wait_timeout;

   assign w_accept       = (r_state == S_IDLE) && job_valid;
   assign w_wait_finish  = (r_state == S_WAIT) && qconv_finish;
   // A finish in the final timeout cycle wins: the pass is counted instead.
   assign w_wait_timeout = (r_state == S_WAIT) && !qconv_finish && (r_timer == TimerLast);

   // Next-state and Moore output decode.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      w_state_nxt = r_state;
      job_ready   = 1'b0;
      qconv_start = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            busy      = 1'b0;
            // Held low during reset so a request cannot appear accepted on
            // the very edge that reset wins.
            job_ready = !rst;
            if (job_valid) begin
               w_state_nxt = (job_count == '0) ? S_DONE : S_START;
            end
         end
         S_START: begin
            qconv_start = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (qconv_finish) begin
               w_state_nxt = (r_remaining == CountOne) ? S_DONE : S_GAP;
            end else if (r_timer == TimerLast) begin
               w_state_nxt = S_DONE;
            end
         end
         // One dead cycle so a new start never follows a finish back to back.
         S_GAP: begin
            w_state_nxt = S_START;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register and job datapath.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         r_state        <= S_IDLE;
         r_remaining    <= '0;
         r_passes_done  <= '0;
         r_timer        <= '0;
         r_timeout_err  <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_accept) begin
            r_remaining    <= job_count;
            r_passes_done  <= '0;
            r_timeout_err  <= 1'b0;
            r_protocol_err <= 1'b0;
         end

         if (r_state == S_START) begin
            r_timer <= '0;
         end else if (r_state == S_WAIT && r_timer != TimerMax) begin
            r_timer <= r_timer + TimeoutWidth'(1);
         end

         if (w_wait_finish) begin
            r_passes_done <= r_passes_done + CountOne;
            r_remaining   <= r_remaining - CountOne;
         end

         if (w_wait_timeout) begin
            r_timeout_err <= 1'b1;
         end

         // Placed after the acceptance clear so a stray finish on the
         // acceptance edge is still reported.
         if (qconv_finish && r_state != S_WAIT) begin
            r_protocol_err <= 1'b1;
         end
      end
   end

   assign passes_done  = r_passes_done;
   assign timeout_err  = r_timeout_err;
   assign protocol_err = r_protocol_err;

endmodule
